// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Latches an N_IN-input boolean function as a truth-table word and evaluates
//   it one input combination per clock. It either sweeps every combination
//   (mode=0) or evaluates a single requested vector (mode=1). Each result is
//   reported with a running count of true minterms.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request a new evaluation (sampled only in IDLE)
//   mode      : 0 = full sweep, 1 = single vector (latched with start)
//   tbl       : truth table, bit i = f(i), MSB of i = first input (latched with start)
//   vec       : input vector for single mode (latched with start)
//   busy      : accepted request in progress, including the done cycle
//   out_valid : out_idx/out_bit valid this cycle
//   out_idx   : input combination being reported
//   out_bit   : tbl[out_idx]
//   ones_cnt  : running count of reported out_bit = 1
//   done      : one-cycle pulse after the last valid result
module truth_table_sweeper #(
  parameter int N_IN = 2,
  parameter int TT_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [TT_W-1:0] tbl,
  input  logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            out_valid,
  output logic [N_IN-1:0] out_idx,
  output logic            out_bit,
  output logic [N_IN:0]   ones_cnt,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

  state_t            state, state_nx;
  logic [TT_W-1:0]   tbl_q, tbl_q_nx;
  logic              mode_q, mode_q_nx;
  logic              busy_nx, out_valid_nx, out_bit_nx, done_nx;
  logic [N_IN-1:0]   out_idx_nx;
  logic [N_IN:0]     ones_cnt_nx;

  logic [N_IN-1:0]   first_idx;
  logic [N_IN-1:0]   idx_inc;

  assign first_idx = mode ? vec : '0;
  assign idx_inc   = out_idx + N_IN'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tbl_q     <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_bit   <= 1'b0;
      ones_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      tbl_q     <= tbl_q_nx;
      mode_q    <= mode_q_nx;
      busy      <= busy_nx;
      out_valid <= out_valid_nx;
      out_idx   <= out_idx_nx;
      out_bit   <= out_bit_nx;
      ones_cnt  <= ones_cnt_nx;
      done      <= done_nx;
    end
  end

  // The registered out_idx doubles as the sweep index, so the first result is
  // loaded on the accepting edge and appears in the cycle after start.
  // ones_cnt accumulates the out_bit already on the outputs, which makes it
  // lag the reported bit by one cycle and settle exactly in the done cycle.
  always_comb begin
    state_nx     = state;
    tbl_q_nx     = tbl_q;
    mode_q_nx    = mode_q;
    busy_nx      = busy;
    out_valid_nx = out_valid;
    out_idx_nx   = out_idx;
    out_bit_nx   = out_bit;
    ones_cnt_nx  = ones_cnt;
    done_nx      = 1'b0;

    case (state)
      IDLE: begin
        busy_nx      = 1'b0;
        out_valid_nx = 1'b0;
        if (start) begin
          state_nx     = EVAL;
          tbl_q_nx     = tbl;
          mode_q_nx    = mode;
          busy_nx      = 1'b1;
          out_valid_nx = 1'b1;
          out_idx_nx   = first_idx;
          out_bit_nx   = tbl[first_idx];
          ones_cnt_nx  = '0;
        end
      end

      EVAL: begin
        ones_cnt_nx = ones_cnt + (N_IN+1)'(out_bit);
        if (!mode_q && (out_idx != IDX_LAST)) begin
          out_idx_nx = idx_inc;
          out_bit_nx = tbl_q[idx_inc];
        end else begin
          state_nx     = FINISH;
          out_valid_nx = 1'b0;
          done_nx      = 1'b1;
        end
      end

      FINISH: begin
        state_nx     = IDLE;
        busy_nx      = 1'b0;
        out_valid_nx = 1'b0;
      end

      default: begin
        state_nx     = IDLE;
        busy_nx      = 1'b0;
        out_valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one N_IN=2 instance and one N_IN=3
// instance sharing clock and reset. Cycle k is the interval after the k-th
// rising edge following the cycle in which start is driven high.
module tb_truth_table_sweeper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N_IN = 2 instance
  logic       start2 = 1'b0;
  logic       mode2  = 1'b0;
  logic [3:0] tbl2   = '0;
  logic [1:0] vec2   = '0;
  logic       busy2, valid2, bit2, done2;
  logic [1:0] idx2;
  logic [2:0] ones2;

  // N_IN = 3 instance
  logic       start3 = 1'b0;
  logic       mode3  = 1'b0;
  logic [7:0] tbl3   = '0;
  logic [2:0] vec3   = '0;
  logic       busy3, valid3, bit3, done3;
  logic [2:0] idx3;
  logic [3:0] ones3;

  int checks   = 0;
  int failures = 0;

  truth_table_sweeper #(.N_IN(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .mode     (mode2),
    .tbl      (tbl2),
    .vec      (vec2),
    .busy     (busy2),
    .out_valid(valid2),
    .out_idx  (idx2),
    .out_bit  (bit2),
    .ones_cnt (ones2),
    .done     (done2)
  );

  truth_table_sweeper #(.N_IN(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .mode     (mode3),
    .tbl      (tbl3),
    .vec      (vec3),
    .busy     (busy3),
    .out_valid(valid3),
    .out_idx  (idx3),
    .out_bit  (bit3),
    .ones_cnt (ones3),
    .done     (done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller drives start2=1 with mode2=0 and tbl2=tt in cycle 0.
  // Returns in the first IDLE cycle after done.
  task automatic sweep2(input logic [3:0] tt, input string tag);
    int exp_ones;
    exp_ones = 0;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, " valid"}, 32'(valid2), 32'd1);
      check({tag, " busy"},  32'(busy2),  32'd1);
      check({tag, " idx"},   32'(idx2),   32'(k));
      check({tag, " bit"},   32'(bit2),   32'(tt[k]));
      check({tag, " ones"},  32'(ones2),  32'(exp_ones));
      check({tag, " done_lo"}, 32'(done2), 32'd0);
      if (tt[k]) exp_ones++;
      tick();
    end
    check({tag, " fin_done"},  32'(done2),  32'd1);
    check({tag, " fin_valid"}, 32'(valid2), 32'd0);
    check({tag, " fin_busy"},  32'(busy2),  32'd1);
    check({tag, " fin_ones"},  32'(ones2),  32'(exp_ones));
    tick();
    check({tag, " idle_done"}, 32'(done2), 32'd0);
    check({tag, " idle_busy"}, 32'(busy2), 32'd0);
    check({tag, " hold_ones"}, 32'(ones2), 32'(exp_ones));
    check({tag, " hold_idx"},  32'(idx2),  32'd3);
  endtask

  initial begin
    logic [7:0] maj;
    logic [3:0] xr;
    int         exp_ones;
    maj = 8'hE8;
    xr  = 4'b0110;

    // Reset state
    tick();
    tick();
    check("rst busy2",  32'(busy2),  32'd0);
    check("rst valid2", 32'(valid2), 32'd0);
    check("rst ones2",  32'(ones2),  32'd0);
    check("rst done2",  32'(done2),  32'd0);
    check("rst valid3", 32'(valid3), 32'd0);
    check("rst ones3",  32'(ones3),  32'd0);
    rst_n = 1'b1;
    tick();

    // XOR full sweep: bits 0,1,1,0, ones=2, done in cycle 5
    tbl2 = xr; mode2 = 1'b0; start2 = 1'b1;
    sweep2(xr, "xor");

    // Single vector 2'b11 of XOR
    tbl2 = xr; mode2 = 1'b1; vec2 = 2'b11; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("single valid", 32'(valid2), 32'd1);
    check("single idx",   32'(idx2),   32'd3);
    check("single bit",   32'(bit2),   32'd0);
    check("single busy",  32'(busy2),  32'd1);
    check("single ones1", 32'(ones2),  32'd0);
    tick();
    check("single fin_valid", 32'(valid2), 32'd0);
    check("single fin_done",  32'(done2),  32'd1);
    check("single fin_ones",  32'(ones2),  32'd0);
    tick();
    check("single idle_busy", 32'(busy2), 32'd0);
    check("single idle_done", 32'(done2), 32'd0);

    // All-ones: ones_cnt reaches 4 without overflow; a second run clears it first
    tbl2 = 4'b1111; mode2 = 1'b0; start2 = 1'b1;
    sweep2(4'b1111, "ones_a");
    start2 = 1'b1;
    sweep2(4'b1111, "ones_b");

    // N_IN=3 majority: true at 3,5,6,7; done in cycle 9
    tbl3 = maj; mode3 = 1'b0; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    exp_ones = 0;
    for (int k = 0; k < 8; k++) begin
      check("maj valid", 32'(valid3), 32'd1);
      check("maj idx",   32'(idx3),   32'(k));
      check("maj bit",   32'(bit3),   32'(maj[k]));
      check("maj ones",  32'(ones3),  32'(exp_ones));
      if (maj[k]) exp_ones++;
      tick();
    end
    check("maj done",     32'(done3),  32'd1);
    check("maj fin_ones", 32'(ones3),  32'd4);
    check("maj fin_valid",32'(valid3), 32'd0);
    tick();
    check("maj idle_busy", 32'(busy3), 32'd0);

    // Mid-sweep start pulses and table changes are ignored
    tbl2 = xr; mode2 = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("mid idx0", 32'(idx2), 32'd0);
    check("mid bit0", 32'(bit2), 32'd0);
    tick();
    for (int k = 1; k < 4; k++) begin
      start2 = (k % 2 == 1);
      tbl2   = 4'b0000;
      check("mid valid", 32'(valid2), 32'd1);
      check("mid idx",   32'(idx2),   32'(k));
      check("mid bit",   32'(bit2),   32'(xr[k]));
      tick();
    end
    start2 = 1'b1;
    check("mid done", 32'(done2), 32'd1);
    check("mid ones", 32'(ones2), 32'd2);
    tick();
    start2 = 1'b0;
    check("mid no_rerun_busy", 32'(busy2), 32'd0);
    tick();
    check("mid no_rerun_busy2",  32'(busy2),  32'd0);
    check("mid no_rerun_valid2", 32'(valid2), 32'd0);

    // Start held high through done is accepted in the following IDLE cycle
    tbl2 = xr; mode2 = 1'b0; start2 = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("held idx", 32'(idx2), 32'(k));
      tick();
    end
    check("held done", 32'(done2), 32'd1);
    tick();
    check("held idle_busy",  32'(busy2),  32'd0);
    check("held idle_valid", 32'(valid2), 32'd0);
    tick();
    start2 = 1'b0;
    check("held rerun_busy",  32'(busy2),  32'd1);
    check("held rerun_valid", 32'(valid2), 32'd1);
    check("held rerun_idx",   32'(idx2),   32'd0);
    check("held rerun_ones",  32'(ones2),  32'd0);
    repeat (4) tick();
    check("held rerun_done", 32'(done2), 32'd1);
    check("held rerun_ones2", 32'(ones2), 32'd2);
    tick();

    // Asynchronous reset in cycle 2 of a sweep
    tbl2 = xr; mode2 = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check("arst pre_idx", 32'(idx2), 32'd1);
    check("arst pre_bit", 32'(bit2), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst busy",  32'(busy2),  32'd0);
    check("arst valid", 32'(valid2), 32'd0);
    check("arst done",  32'(done2),  32'd0);
    check("arst idx",   32'(idx2),   32'd0);
    check("arst bit",   32'(bit2),   32'd0);
    check("arst ones",  32'(ones2),  32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("arst idle_busy",  32'(busy2),  32'd0);
    check("arst idle_valid", 32'(valid2), 32'd0);
    check("arst idle_done",  32'(done2),  32'd0);
    check("arst idle_ones",  32'(ones2),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, clocked successor to the team's fixed two-input expression blocks. It latches an arbitrary N_IN-input boolean function as a truth-table word, then evaluates it one input combination per clock. It either sweeps all 2^N_IN combinations or evaluates a single requested vector, and reports each result plus a running count of true minterms. It sits between stimulus logic and checkers, and replaces hand-written exhaustive `for` loops for small combinational functions.

## Interface

Parameters:
- N_IN, 2, number of function inputs; legal range 1..8.
- TT_W, 2**N_IN, truth-table width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new evaluation; sampled only in IDLE.
- mode  in  1  0 = full sweep, 1 = single vector; latched with start.
- table  in  TT_W  truth table; bit i is f(i) with input vector i, MSB of vector = first input; latched with start.
- vec  in  N_IN  vector for single mode; latched with start.
- busy  out  1  high while an accepted request is in progress, including the done cycle.
- out_valid  out  1  out_idx/out_bit valid this cycle.
- out_idx  out  N_IN  input combination being reported.
- out_bit  out  1  table[out_idx].
- ones_cnt  out  N_IN+1  running count of reported out_bit = 1.
- done  out  1  one-cycle pulse after the last valid result.

## Operation

- All outputs are registered.
- States:
  - IDLE: busy=0, out_valid=0.
    - start=1 latches table, mode and vec, clears ones_cnt to 0, and moves to EVAL.
    - EVAL index = 0 in sweep mode, or vec in single mode.
  - EVAL: each cycle drives out_valid=1, out_idx=index and out_bit=table_latched[index]. ones_cnt increments when out_bit=1.
    - Sweep mode: index increments each cycle. After index TT_W-1, go to FINISH.
    - Single mode: one EVAL cycle, then FINISH.
  - FINISH: out_valid=0, done=1, busy=1 for one cycle, then IDLE.
- The index counter is N_IN bits wide. Its wrap from TT_W-1 to 0 is never reported; the terminal compare is done on TT_W-1.
- ones_cnt is N_IN+1 bits, so an all-ones table (TT_W) does not overflow. It holds its final value in IDLE until the next accepted start.
- out_idx and out_bit hold their last values when out_valid=0. Consumers must qualify them with out_valid.
- start is ignored in EVAL and FINISH, including the FINISH cycle. It is accepted on the next IDLE cycle.
- Changes on table, mode or vec after acceptance have no effect on the running evaluation.
- Reset (rst_n=0, at any time, including mid-sweep):
  - state returns to IDLE immediately.
  - busy, out_valid, done, out_idx, out_bit and ones_cnt all go to 0.
  - the latched table is cleared to 0.

## Timing

- Cycle 0: start sampled high in IDLE.
- Cycle 1: busy=1, first out_valid=1.
- Sweep mode:
  - out_valid is high for cycles 1..TT_W with out_idx = 0..TT_W-1 in order, no gaps.
  - done and FINISH occur in cycle TT_W+1.
  - IDLE is reached in cycle TT_W+2.
  - Start-to-done latency is TT_W+1 cycles.
- Single mode: out_valid in cycle 1, done in cycle 2, IDLE in cycle 3.
- ones_cnt visible in cycle k includes out_bit of cycles up to k-1 (registered accumulate). Its final value is stable from the done cycle onward.
- Back-to-back requests: minimum spacing of start edges is TT_W+2 cycles in sweep mode and 3 cycles in single mode.

## Test plan

- N_IN=2, table=4'b0110 (XOR), mode=0:
  - out_idx 0,1,2,3 with out_bit 0,1,1,0 in cycles 1..4.
  - done in cycle 5, ones_cnt=2.
- N_IN=2, table=4'b0110, mode=1, vec=2'b11: out_valid only in cycle 1 with out_idx=3, out_bit=0; done in cycle 2, ones_cnt=0.
- N_IN=2, table=4'b1111, mode=0: ones_cnt=3'd4 at done, with no overflow. A second start clears ones_cnt to 0 before re-accumulating.
- N_IN=3, table=8'hE8 (majority), mode=0: out_bit is 1 exactly at idx 3,5,6,7; ones_cnt=4; done in cycle 9.
- Mid-sweep robustness, N_IN=2, table=4'b0110:
  - start pulses and table changes to 4'b0000 during cycles 2..5: the sweep output is unchanged and no second run starts.
  - a start held high through the done cycle is accepted in the following IDLE cycle.
- rst_n=0 asynchronously in cycle 2 of a sweep: all outputs read 0 before the next clock edge. After release, the block stays idle until a new start.
